pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage mini CPU. Drives valid (advance)
//  and flush of IF/ID, ID/EX, EX/MEM, MEM/WB and the PC enable/redirect select.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 31 +++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// Module  : pipe_hazard_ctrl_pkg
// Brief   : FSM encodings and the load-use hazard helper for pipe_hazard_ctrl
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DWAIT = 2'd1;
   localparam logic [1:0] ST_DROP  = 2'd2;

   localparam logic [4:0] REG_X0 = 5'd0;

   // x0 is hardwired to zero, so a load targeting it never creates a dependency
   function automatic logic load_use_hit(
      input logic       mem_read,
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic       rs1_used,
      input logic       rs2_used
   );
      return mem_read && (rd != REG_X0) &&
             ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ============================================================================
// Module  : pipe_hazard_ctrl_sat_counter
// Brief   : Up-counter that sticks at all-ones, with synchronous clear
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : Stall/flush sequencer for the 5-stage pipeline with statistics
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W        = 32,
   parameter int DMEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             imem_rvalid,
   input  logic             imem_pending,
   input  logic             dmem_busy,
   output logic             pc_en,
   output logic             pc_redirect,
   output logic             if_id_valid,
   output logic             if_id_flush,
   output logic             id_ex_valid,
   output logic             id_ex_flush,
   output logic             ex_mem_valid,
   output logic             mem_wb_valid,
   output logic             fetch_discard,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mem_timeout
);

   localparam int              TMO_W    = $clog2(DMEM_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DMEM_TIMEOUT - 1);

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic             mem_timeout_q;
   logic             mem_timeout_d;
   logic [TMO_W-1:0] tmo_cnt;
   logic             load_use;

   logic pc_en_c;
   logic pc_redirect_c;
   logic if_id_valid_c;
   logic if_id_flush_c;
   logic id_ex_valid_c;
   logic id_ex_flush_c;
   logic ex_mem_valid_c;
   logic mem_wb_valid_c;
   logic fetch_discard_c;

   assign load_use = load_use_hit(ex_mem_read, ex_rd, id_rs1, id_rs2,
                                  id_rs1_used, id_rs2_used);

   always_comb begin
      state_d         = state_q;
      pc_en_c         = 1'b0;
      pc_redirect_c   = 1'b0;
      if_id_valid_c   = 1'b0;
      if_id_flush_c   = 1'b0;
      id_ex_valid_c   = 1'b0;
      id_ex_flush_c   = 1'b0;
      ex_mem_valid_c  = 1'b0;
      mem_wb_valid_c  = 1'b0;
      fetch_discard_c = 1'b0;

      if (dmem_busy) begin
         // Whole pipe frozen; DWAIT and DROP keep their state
         if (state_q == ST_RUN) begin
            state_d = ST_DWAIT;
         end
      end else if (state_q == ST_DROP) begin
         if_id_flush_c  = 1'b1;
         id_ex_valid_c  = 1'b1;
         ex_mem_valid_c = 1'b1;
         mem_wb_valid_c = 1'b1;
         if (imem_rvalid) begin
            fetch_discard_c = 1'b1;
            state_d         = ST_RUN;
         end
      end else begin
         state_d = ST_RUN;
         if (ex_branch_taken) begin
            pc_en_c        = 1'b1;
            pc_redirect_c  = 1'b1;
            if_id_flush_c  = 1'b1;
            id_ex_flush_c  = 1'b1;
            ex_mem_valid_c = 1'b1;
            mem_wb_valid_c = 1'b1;
            // A response still in flight belongs to the wrong path
            if (imem_pending && !imem_rvalid) begin
               state_d = ST_DROP;
            end
         end else if (load_use) begin
            id_ex_flush_c  = 1'b1;
            ex_mem_valid_c = 1'b1;
            mem_wb_valid_c = 1'b1;
         end else if (!imem_rvalid) begin
            if_id_flush_c  = 1'b1;
            id_ex_valid_c  = 1'b1;
            ex_mem_valid_c = 1'b1;
            mem_wb_valid_c = 1'b1;
         end else begin
            pc_en_c        = 1'b1;
            if_id_valid_c  = 1'b1;
            id_ex_valid_c  = 1'b1;
            ex_mem_valid_c = 1'b1;
            mem_wb_valid_c = 1'b1;
         end
      end
   end

   always_comb begin
      mem_timeout_d = mem_timeout_q;
      if (dmem_busy && (tmo_cnt >= TMO_LAST)) begin
         mem_timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_RUN;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   pipe_hazard_ctrl_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (!pc_en_c),
      .count (stall_cnt)
   );

   pipe_hazard_ctrl_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (pc_redirect_c),
      .count (flush_cnt)
   );

   // Counts consecutive busy cycles in any state
   pipe_hazard_ctrl_sat_counter #(.WIDTH(TMO_W)) u_tmo_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (!dmem_busy),
      .inc   (dmem_busy),
      .count (tmo_cnt)
   );

   assign pc_en         = pc_en_c         & ~reset;
   assign pc_redirect   = pc_redirect_c   & ~reset;
   assign if_id_valid   = if_id_valid_c   & ~reset;
   assign if_id_flush   = if_id_flush_c   & ~reset;
   assign id_ex_valid   = id_ex_valid_c   & ~reset;
   assign id_ex_flush   = id_ex_flush_c   & ~reset;
   assign ex_mem_valid  = ex_mem_valid_c  & ~reset;
   assign mem_wb_valid  = mem_wb_valid_c  & ~reset;
   assign fetch_discard = fetch_discard_c & ~reset;
   assign state_o       = state_q;
   assign mem_timeout   = mem_timeout_q;

   // EX holds a bubble while a stale fetch is being dropped
   a_no_branch_in_drop : assert property (
      @(posedge clk) disable iff (reset) (state_q == ST_DROP) |-> !ex_branch_taken
   );

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Brief   : Directed + random checks of pipe_hazard_ctrl against a rule model
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_hazard_ctrl;

   localparam int CNT_W        = 6;
   localparam int DMEM_TIMEOUT = 4;
   localparam int CNT_MAX      = (1 << CNT_W) - 1;

   // Model situations, one per row of the behaviour table
   localparam int K_FREEZE   = 0;
   localparam int K_BRANCH   = 1;
   localparam int K_LOADUSE  = 2;
   localparam int K_NOFETCH  = 3;
   localparam int K_RUN      = 4;
   localparam int K_DROPWAIT = 5;
   localparam int K_DROPDONE = 6;

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       id_rs1, id_rs2, ex_rd;
   logic             id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken;
   logic             imem_rvalid, imem_pending, dmem_busy;
   logic             pc_en, pc_redirect, if_id_valid, if_id_flush;
   logic             id_ex_valid, id_ex_flush, ex_mem_valid, mem_wb_valid;
   logic             fetch_discard, mem_timeout;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [8:0]       dut_ctl;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(CNT_W), .DMEM_TIMEOUT(DMEM_TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .imem_rvalid(imem_rvalid), .imem_pending(imem_pending), .dmem_busy(dmem_busy),
      .pc_en(pc_en), .pc_redirect(pc_redirect), .if_id_valid(if_id_valid), .if_id_flush(if_id_flush),
      .id_ex_valid(id_ex_valid), .id_ex_flush(id_ex_flush), .ex_mem_valid(ex_mem_valid),
      .mem_wb_valid(mem_wb_valid), .fetch_discard(fetch_discard), .state_o(state_o),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
   );

   // {pc_en, pc_redirect, if_id_v, if_id_f, id_ex_v, id_ex_f, ex_mem_v, mem_wb_v, discard}
   assign dut_ctl = {pc_en, pc_redirect, if_id_valid, if_id_flush, id_ex_valid,
                     id_ex_flush, ex_mem_valid, mem_wb_valid, fetch_discard};

   int         n_tests = 0;
   int         n_fail  = 0;
   int         m_state;
   int         m_next;
   int         m_stall;
   int         m_flush;
   int         m_busy_run;
   bit         m_tmo;
   logic [8:0] m_ctl;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      assert (act === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state    = 0;
      m_stall    = 0;
      m_flush    = 0;
      m_busy_run = 0;
      m_tmo      = 1'b0;
   endtask

   task automatic predict();
      bit lu;
      int kind;
      lu = ex_mem_read && (ex_rd != 0) &&
           ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
      if (dmem_busy)            kind = K_FREEZE;
      else if (m_state == 2)    kind = imem_rvalid ? K_DROPDONE : K_DROPWAIT;
      else if (ex_branch_taken) kind = K_BRANCH;
      else if (lu)              kind = K_LOADUSE;
      else if (!imem_rvalid)    kind = K_NOFETCH;
      else                      kind = K_RUN;
      case (kind)
         K_FREEZE:   m_ctl = 9'b0_0_0_0_0_0_0_0_0;
         K_BRANCH:   m_ctl = 9'b1_1_0_1_0_1_1_1_0;
         K_LOADUSE:  m_ctl = 9'b0_0_0_0_0_1_1_1_0;
         K_NOFETCH:  m_ctl = 9'b0_0_0_1_1_0_1_1_0;
         K_DROPWAIT: m_ctl = 9'b0_0_0_1_1_0_1_1_0;
         K_DROPDONE: m_ctl = 9'b0_0_0_1_1_0_1_1_1;
         default:    m_ctl = 9'b1_0_1_0_1_0_1_1_0;
      endcase
      case (kind)
         K_FREEZE:   m_next = (m_state == 0) ? 1 : m_state;
         K_BRANCH:   m_next = (imem_pending && !imem_rvalid) ? 2 : 0;
         K_DROPWAIT: m_next = 2;
         default:    m_next = 0;
      endcase
   endtask

   task automatic drive(input bit busy, input bit br, input bit rv, input bit pend,
                        input bit mr, input int rd, input int rs1, input int rs2,
                        input bit u1, input bit u2);
      dmem_busy       = busy;
      ex_branch_taken = br;
      imem_rvalid     = rv;
      imem_pending    = pend;
      ex_mem_read     = mr;
      ex_rd           = 5'(rd);
      id_rs1          = 5'(rs1);
      id_rs2          = 5'(rs2);
      id_rs1_used     = u1;
      id_rs2_used     = u2;
   endtask

   // One clock: check combinational controls mid-cycle, then registered state
   task automatic step(input string tag);
      #1;
      predict();
      check({tag, ".ctl"}, 32'(dut_ctl), 32'(m_ctl));
      @(posedge clk);
      #1;
      if (!m_ctl[8] && m_stall < CNT_MAX) m_stall++;
      if (m_ctl[7] && m_flush < CNT_MAX) m_flush++;
      m_busy_run = dmem_busy ? m_busy_run + 1 : 0;
      if (m_busy_run >= DMEM_TIMEOUT) m_tmo = 1'b1;
      m_state = m_next;
      check({tag, ".state"}, 32'(state_o), 32'(m_state));
      check({tag, ".stall"}, 32'(stall_cnt), 32'(m_stall));
      check({tag, ".flush"}, 32'(flush_cnt), 32'(m_flush));
      check({tag, ".tmo"}, 32'(mem_timeout), 32'(m_tmo));
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2;
      reset = 1'b1;
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      model_reset();
      check("rst.ctl", 32'(dut_ctl), 32'd0);
      check("rst.state", 32'(state_o), 32'd0);
      check("rst.stall", 32'(stall_cnt), 32'd0);
      check("rst.flush", 32'(flush_cnt), 32'd0);
      check("rst.tmo", 32'(mem_timeout), 32'd0);
      @(posedge clk);
      #1;
      check("rst.ctl_hold", 32'(dut_ctl), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      apply_reset();

      // Load-use on rs1, then the same pattern against x0
      drive(0, 0, 1, 0, 1, 5, 5, 9, 1, 0);
      step("lu");
      check("lu.stall_is_1", 32'(stall_cnt), 32'd1);
      drive(0, 0, 1, 0, 1, 0, 0, 0, 1, 1);
      step("lu_x0");
      check("lu_x0.stall_still_1", 32'(stall_cnt), 32'd1);

      // Redirect with stale fetch outstanding, response three cycles later
      drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      step("br_drop");
      check("br_drop.in_drop", 32'(state_o), 32'd2);
      drive(0, 0, 0, 1, 1, 3, 3, 0, 1, 0);
      step("drop_w1");
      step("drop_w2");
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      step("drop_done");
      check("drop_done.flush_is_1", 32'(flush_cnt), 32'd1);

      // Data-memory wait masks a pending branch for five cycles
      apply_reset();
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step("busy_br");
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      step("busy_br_go");
      check("busy_br.stall_is_5", 32'(stall_cnt), 32'd5);
      check("busy_br.flush_is_1", 32'(flush_cnt), 32'd1);

      // Timeout sets after the fourth busy cycle and sticks
      apply_reset();
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step("tmo");
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      step("tmo_after");
      check("tmo.sticky", 32'(mem_timeout), 32'd1);

      // Load-use wins over a missing fetch
      drive(0, 0, 0, 1, 1, 7, 1, 7, 0, 1);
      step("lu_nofetch");

      // Reach DROP with stall_cnt 7, then reset mid-operation
      apply_reset();
      drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step("pre_drop");
      drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      step("pre_drop_br");
      drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      step("pre_drop_w");
      check("pre_drop.stall_is_7", 32'(stall_cnt), 32'd7);
      check("pre_drop.in_drop", 32'(state_o), 32'd2);
      apply_reset();

      // Randomised traffic; small register range keeps hazards frequent
      for (int n = 0; n < 2000; n++) begin
         drive($urandom_range(0, 4) == 0,
               (m_state != 2) && ($urandom_range(0, 5) == 0),
               $urandom_range(0, 2) != 0,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         step("rnd");
      end
      check("rnd.stall_saturated", 32'(stall_cnt), 32'(CNT_MAX));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
